// File: rtl/ccl_label_scan.sv
// First pass of connected-component labelling: raster-scans binary pixels, emits provisional
// labels and union(a,b) requests for union_find. Define CCL_CONN8_EN for 8-connectivity.
module ccl_label_scan #(
    parameter int N          = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WIDTH  = 1280,
    parameter int COL_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic                  pix_bin,
    input  logic                  pix_eol,
    output logic                  lab_valid,
    output logic [ADDR_WIDTH-1:0] lab_label,
    output logic                  lab_eol,
    output logic                  uf_frame_start,
    output logic [1:0]            uf_op,
    output logic [ADDR_WIDTH-1:0] uf_node1,
    output logic [ADDR_WIDTH-1:0] uf_node2,
    input  logic                  uf_done,
    input  logic                  uf_idle,
    output logic [ADDR_WIDTH-1:0] label_count,
    output logic                  overflow
);
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_INIT, S_RUN, S_UWAIT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_LABEL = ADDR_WIDTH'(N - 1);
    localparam logic [COL_WIDTH-1:0]  LAST_COL   = COL_WIDTH'(MAX_WIDTH - 1);

    state_t                state, next_state;
    logic                  pending, init_skip, sync_fire, accept, need_union, take_new;
    logic [COL_WIDTH-1:0]  col, row, prev_last;
    logic [ADDR_WIDTH-1:0] prev_label, up, left, label, other;
    logic [ADDR_WIDTH-1:0] line_buf [MAX_WIDTH];

    // Gating on uf_idle guarantees a union is never issued into a busy union_find.
    assign pix_ready = (state == S_RUN) && uf_idle && !frame_start;
    assign accept    = pix_valid && pix_ready;

    // prev_last bounds U to the columns the previous row actually wrote.
    assign up   = (row != '0 && col <= prev_last) ? line_buf[col] : '0;
    assign left = (col != '0) ? prev_label : '0;

`ifdef CCL_CONN8_EN
    logic [ADDR_WIDTH-1:0] prev_up, up_left, up_right, x_label;
    logic [COL_WIDTH-1:0]  col_right;

    // UL is the U seen by the previous pixel; line_buf[c-1] already holds this row's label.
    assign col_right = col + COL_WIDTH'(1);
    assign up_left   = (col != '0) ? prev_up : '0;
    assign up_right  = (row != '0 && col != LAST_COL && col_right <= prev_last) ?
                       line_buf[col_right] : '0;
    assign x_label   = (left != '0) ? left : up_left;
`endif

    always_comb begin
        // NOTE: every always_comb output is given a default first, so no latch can be inferred.
        label      = '0;
        other      = '0;
        need_union = 1'b0;
        take_new   = 1'b0;
        if (pix_bin) begin
`ifdef CCL_CONN8_EN
            if (up != '0) begin
                label = up;
            end else if (up_right != '0) begin
                label = up_right;
                if (x_label != '0 && x_label != up_right) begin
                    need_union = 1'b1;
                    other      = x_label;
                end
            end else if (left != '0) begin
                label = left;
            end else if (up_left != '0) begin
                label = up_left;
            end else begin
                take_new = 1'b1;
            end
`else
            if (up != '0) begin
                label = up;
                if (left != '0 && left != up) begin
                    need_union = 1'b1;
                    other      = left;
                end
            end else if (left != '0) begin
                label = left;
            end else begin
                take_new = 1'b1;
            end
`endif
            if (take_new)
                label = (label_count == LAST_LABEL) ? LAST_LABEL : label_count + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        sync_fire  = 1'b0;
        case (state)
            S_SYNC:  if (uf_idle) begin
                         sync_fire  = 1'b1;
                         next_state = S_INIT;
                     end
            S_INIT:  if (!init_skip && uf_idle) next_state = S_RUN;
            S_RUN:   if (accept && need_union) next_state = S_UWAIT;
            S_UWAIT: if (uf_done) next_state = (pending || frame_start) ? S_SYNC : S_RUN;
            default: next_state = state;
        endcase
        // An in-flight union must complete first; S_UWAIT picks up the pending flag.
        if (frame_start && state != S_UWAIT) begin
            next_state = S_SYNC;
            sync_fire  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (reset) begin
            pending        <= 1'b0;
            init_skip      <= 1'b0;
            uf_frame_start <= 1'b0;
            lab_valid      <= 1'b0;
            lab_label      <= '0;
            lab_eol        <= 1'b0;
            uf_op          <= 2'b00;
            uf_node1       <= '0;
            uf_node2       <= '0;
            label_count    <= '0;
            overflow       <= 1'b0;
            col            <= '0;
            row            <= '0;
            prev_last      <= '0;
            prev_label     <= '0;
`ifdef CCL_CONN8_EN
            prev_up        <= '0;
`endif
        end else begin
            init_skip      <= sync_fire;
            uf_frame_start <= sync_fire;
            lab_valid      <= accept;
            uf_op          <= (accept && need_union) ? 2'b01 : 2'b00;
            if (accept) begin
                lab_label <= label;
                lab_eol   <= pix_eol;
            end
            if (accept && need_union) begin
                uf_node1 <= label;
                uf_node2 <= other;
            end
            if (frame_start)    pending <= 1'b1;
            else if (sync_fire) pending <= 1'b0;

            if (frame_start) begin
                label_count <= '0;
                overflow    <= 1'b0;
                col         <= '0;
                row         <= '0;
                prev_last   <= '0;
                prev_label  <= '0;
            end else if (accept) begin
                if (take_new) begin
                    if (label_count == LAST_LABEL) overflow <= 1'b1;
                    else                           label_count <= label_count + ADDR_WIDTH'(1);
                end
                prev_label <= label;
`ifdef CCL_CONN8_EN
                prev_up    <= up;
`endif
                if (pix_eol) begin
                    col       <= '0;
                    prev_last <= col;
                    if (row != '1) row <= row + COL_WIDTH'(1);
                end else if (col != LAST_COL) begin
                    col <= col + COL_WIDTH'(1);
                end
            end
        end
    end

    // NOTE: the line buffer is deliberately not reset; row 0 and prev_last mask stale entries.
    always_ff @(posedge clk) begin
        if (accept) line_buf[col] <= label;
    end
endmodule

// File: tb/tb_ccl_label_scan.sv
// Bench for ccl_label_scan: union_find stub, 2-D array reference model, per-cycle compare.
// Honours CCL_CONN8_EN the same way as the design.
module tb_ccl_label_scan;
    localparam int N = 256;

    logic clk = 1'b0;
    logic reset, frame_start, pix_valid, pix_bin, pix_eol, uf_done, uf_idle;
    logic pix_ready, lab_valid, lab_eol, uf_frame_start, overflow;
    logic [7:0] lab_label, uf_node1, uf_node2, label_count;
    logic [1:0] uf_op;

    always #5 clk = ~clk;

    ccl_label_scan dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_bin(pix_bin), .pix_eol(pix_eol),
        .lab_valid(lab_valid), .lab_label(lab_label), .lab_eol(lab_eol),
        .uf_frame_start(uf_frame_start), .uf_op(uf_op), .uf_node1(uf_node1), .uf_node2(uf_node2),
        .uf_done(uf_done), .uf_idle(uf_idle), .label_count(label_count), .overflow(overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // union_find stand-in: N-cycle init after frame_start, uf_delay-cycle union then done.
    int uf_delay = 3;
    int uf_cnt;
    bit uf_busy_union;
    always @(posedge clk) begin
        if (reset) begin
            uf_idle <= 1'b1; uf_done <= 1'b0; uf_cnt <= 0; uf_busy_union <= 1'b0;
        end else begin
            uf_done <= 1'b0;
            if (uf_frame_start) begin
                uf_idle <= 1'b0; uf_cnt <= N; uf_busy_union <= 1'b0;
            end else if (uf_op == 2'b01) begin
                uf_idle <= 1'b0; uf_cnt <= uf_delay; uf_busy_union <= 1'b1;
            end else if (uf_cnt > 0) begin
                uf_cnt <= uf_cnt - 1;
                if (uf_cnt == 1) begin
                    uf_idle <= 1'b1;
                    uf_done <= uf_busy_union;
                end
            end
        end
    end

    // Reference model storage: image, per-frame label grid, expected streams.
    bit   img  [0:15][0:511];
    int   mlab [0:15][0:511];
    logic [7:0] exp_lab [0:4095];
    bit         exp_eol [0:4095];
    logic [7:0] exp_ua  [0:1023];
    logic [7:0] exp_ub  [0:1023];
    int exp_lab_tail = 0, exp_un_tail = 0;
    int m_count;
    bit m_ovf;

    task automatic model_frame(input int rows, input int width, input int npix);
        int r, c, u, l, ul, ur, x, lb, cnt;
        bit ovf;
        cnt = 0;
        ovf = 1'b0;
        for (int idx = 0; idx < npix; idx++) begin
            r  = idx / width;
            c  = idx % width;
            u  = (r > 0) ? mlab[r-1][c] : 0;
            l  = (c > 0) ? mlab[r][c-1] : 0;
            ul = (r > 0 && c > 0) ? mlab[r-1][c-1] : 0;
            ur = (r > 0 && c + 1 < width) ? mlab[r-1][c+1] : 0;
            lb = 0;
            if (img[r][c]) begin
`ifdef CCL_CONN8_EN
                if (u != 0) lb = u;
                else if (ur != 0) begin
                    lb = ur;
                    x  = (l != 0) ? l : ul;
                    if (x != 0 && x != ur) begin
                        exp_ua[exp_un_tail] = 8'(ur); exp_ub[exp_un_tail] = 8'(x); exp_un_tail++;
                    end
                end
                else if (l != 0) lb = l;
                else if (ul != 0) lb = ul;
`else
                if (u != 0) begin
                    lb = u;
                    if (l != 0 && l != u) begin
                        exp_ua[exp_un_tail] = 8'(u); exp_ub[exp_un_tail] = 8'(l); exp_un_tail++;
                    end
                end
                else if (l != 0) lb = l;
`endif
                if (lb == 0) begin
                    if (cnt == N - 1) begin lb = N - 1; ovf = 1'b1; end
                    else begin cnt++; lb = cnt; end
                end
            end
            mlab[r][c] = lb;
            exp_lab[exp_lab_tail] = 8'(lb);
            exp_eol[exp_lab_tail] = (c == width - 1);
            exp_lab_tail++;
        end
        m_count = cnt;
        m_ovf   = ovf;
    endtask

    // Compare process state (written only by the monitors below).
    bit acc_prev = 1'b0;
    int cyc = 0;
    int exp_lab_head = 0, exp_un_head = 0;
    logic [7:0] got_lab [0:4095];
    int got_n = 0, union_seen = 0, sync_seen = 0, done_seen = 0;
    int last_sync_cyc = -1, last_done_cyc = -1;
    logic [7:0] last_ua, last_ub;
    bit in_union = 1'b0;

    always @(posedge clk) begin
        acc_prev <= !reset && pix_valid && pix_ready;
        cyc      <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (lab_valid || acc_prev) check("lab_valid_timing", lab_valid, acc_prev);
            if (lab_valid) begin
                if (exp_lab_head >= exp_lab_tail) check("lab_unexpected", 1, 0);
                else begin
                    check("lab_label", lab_label, exp_lab[exp_lab_head]);
                    check("lab_eol", lab_eol, exp_eol[exp_lab_head]);
                    exp_lab_head++;
                end
                got_lab[got_n] = lab_label;
                got_n++;
            end
            if (in_union) check("ready_during_union", pix_ready, 0);
            if (uf_done) begin
                in_union = 1'b0; done_seen++; last_done_cyc = cyc;
            end
            if (uf_op != 2'b00) begin
                check("uf_op_code", uf_op, 1);
                check("uf_op_idle", uf_idle, 1);
                check("uf_op_after_accept", acc_prev, 1);
                if (exp_un_head >= exp_un_tail) check("uf_op_unexpected", 1, 0);
                else begin
                    check("uf_node1", uf_node1, exp_ua[exp_un_head]);
                    check("uf_node2", uf_node2, exp_ub[exp_un_head]);
                    exp_un_head++;
                end
                last_ua = uf_node1; last_ub = uf_node2;
                union_seen++;
                in_union = 1'b1;
            end
            if (uf_frame_start) begin
                sync_seen++; last_sync_cyc = cyc;
            end
        end
    end

    int fs_wait, fs_pulses, fs_count, fs_ovf, fs_idle;

    task automatic start_frame();
        int s0, b;
        s0 = sync_seen;
        b  = 0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        fs_count = label_count;
        fs_ovf   = overflow;
        while (!pix_ready && b < 2000) begin @(negedge clk); b++; end
        check("frame_ready_timeout", pix_ready, 1);
        fs_wait   = b + 1;
        fs_pulses = sync_seen - s0;
        fs_idle   = uf_idle;
    endtask

    task automatic drive_pixels(input int width, input int npix);
        int r, c, b;
        for (int idx = 0; idx < npix; idx++) begin
            r = idx / width;
            c = idx % width;
            if ($urandom_range(0, 4) == 0) begin pix_valid = 1'b0; @(negedge clk); end
            pix_valid = 1'b1;
            pix_bin   = img[r][c];
            pix_eol   = (c == width - 1);
            b = 0;
            while (!pix_ready && b < 500) begin @(negedge clk); b++; end
            if (!pix_ready) check("pix_ready_timeout", 0, 1);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_eol   = 1'b0;
    endtask

    task automatic settle();
        int b;
        b = 0;
        while ((exp_lab_head != exp_lab_tail || exp_un_head != exp_un_tail || !pix_ready) && b < 500) begin
            @(negedge clk); b++;
        end
        check("settle_timeout", int'(b < 500), 1);
        check("label_count", label_count, m_count);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic run_frame(input int rows, input int width, input int npix);
        start_frame();
        model_frame(rows, width, npix);
        drive_pixels(width, npix);
        settle();
    endtask

    task automatic clear_img();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 512; c++) img[r][c] = 1'b0;
    endtask

    // bits: MSB is column 0
    task automatic set_row(input int r, input int w, input logic [31:0] bits);
        for (int c = 0; c < w; c++) img[r][c] = bits[w-1-c];
    endtask

    int g0, u0, d0, npix_e;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_bin = 1'b0; pix_eol = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_lab_valid", lab_valid, 0);
        check("rst_lab_label", lab_label, 0);
        check("rst_lab_eol", lab_eol, 0);
        check("rst_uf_frame_start", uf_frame_start, 0);
        check("rst_uf_op", uf_op, 0);
        check("rst_uf_nodes", {uf_node1, uf_node2}, 0);
        check("rst_label_count", label_count, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_pix_ready", pix_ready, 0);

        // Frame sync handshake, then row 1,1,0,1.
        clear_img();
        set_row(0, 4, 32'b1101);
        g0 = got_n; u0 = union_seen;
        run_frame(1, 4, 4);
        check("sync_pulses", fs_pulses, 1);
        check("sync_ready_low_ge_n2", int'(fs_wait >= N + 2), 1);
        check("sync_idle_at_ready", fs_idle, 1);
        check("model_row0_count", m_count, 2);
        check("row0_lab0", got_lab[g0], 1);
        check("row0_lab1", got_lab[g0+1], 1);
        check("row0_lab2", got_lab[g0+2], 0);
        check("row0_lab3", got_lab[g0+3], 2);
        check("row0_no_union", union_seen - u0, 0);

        // 1,0,1 / 1,1,1: one union(2,1).
        clear_img();
        set_row(0, 3, 32'b101);
        set_row(1, 3, 32'b111);
        g0 = got_n; u0 = union_seen;
        run_frame(2, 3, 6);
        check("u_lab_r1c0", got_lab[g0+3], 1);
`ifdef CCL_CONN8_EN
        check("u_lab_r1c1", got_lab[g0+4], 2);
`else
        check("u_lab_r1c1", got_lab[g0+4], 1);
`endif
        check("u_lab_r1c2", got_lab[g0+5], 2);
        check("u_count", union_seen - u0, 1);
        check("u_node1", last_ua, 2);
        check("u_node2", last_ub, 1);

        // 1,0,0 / 0,1,0: diagonal joins only with 8-connectivity.
        clear_img();
        set_row(0, 3, 32'b100);
        set_row(1, 3, 32'b010);
        g0 = got_n;
        run_frame(2, 3, 6);
`ifdef CCL_CONN8_EN
        check("diag_label", got_lab[g0+4], 1);
`else
        check("diag_label", got_lab[g0+4], 2);
`endif

        // 256 isolated pixels: label space exhausts.
        clear_img();
        for (int c = 0; c < 511; c++) img[0][c] = (c % 2 == 0);
        g0 = got_n;
        run_frame(1, 511, 511);
        check("ovf_model_flag", m_ovf, 1);
        check("ovf_label_254", got_lab[g0+506], 254);
        check("ovf_label_255", got_lab[g0+508], 255);
        check("ovf_last_label", got_lab[g0+510], 255);
        check("ovf_count", label_count, 255);
        check("ovf_flag", overflow, 1);

        // frame_start while a union is outstanding.
        clear_img();
        set_row(0, 3, 32'b101);
        set_row(1, 3, 32'b111);
`ifdef CCL_CONN8_EN
        npix_e = 5;
`else
        npix_e = 6;
`endif
        uf_delay = 30;
        start_frame();
        check("ovf_cleared", fs_ovf, 0);
        check("count_cleared", fs_count, 0);
        model_frame(2, 3, npix_e);
        drive_pixels(3, npix_e);
        @(negedge clk);
        d0 = done_seen;
        start_frame();
        check("uw_count_zero", fs_count, 0);
        check("uw_done_once", done_seen - d0, 1);
        check("uw_sync_after_done", int'(last_sync_cyc > last_done_cyc), 1);
        check("uw_sync_pulses", fs_pulses, 1);
        uf_delay = 3;
        clear_img();
        set_row(0, 1, 32'b1);
        g0 = got_n;
        model_frame(1, 1, 1);
        drive_pixels(1, 1);
        settle();
        check("uw_first_label", got_lab[g0], 1);

        // Randomised frames against the model.
        for (int f = 0; f < 6; f++) begin
            int rows, width, dens;
            rows  = $urandom_range(2, 8);
            width = $urandom_range(2, 24);
            dens  = $urandom_range(30, 80);
            uf_delay = $urandom_range(1, 5);
            clear_img();
            for (int r = 0; r < rows; r++)
                for (int c = 0; c < width; c++) img[r][c] = ($urandom_range(0, 99) < dens);
            run_frame(rows, width, rows * width);
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
